// File: rtl/adc_pkg.sv
// adc_pkg: shared ADC sample width, default FIFO depth and sample type
package adc_pkg;
  localparam int ADC_DATA_W     = 8;
  localparam int ADC_FIFO_DEPTH = 16;
  typedef logic [ADC_DATA_W-1:0] sample_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: generic show-ahead FIFO with push/pop/clear, level, full and empty
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Clear,
  input  logic              Push,
  input  logic              Pop,
  input  logic [DATA_W-1:0] WrData,
  output logic [DATA_W-1:0] RdData,
  output logic [ADDR_W:0]   Level,
  output logic              Full,
  output logic              Empty
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   level;
  logic              pop_ok, push_ok;
  assign Empty   = level == '0;
  assign Full    = level == (ADDR_W+1)'(DEPTH);
  assign pop_ok  = Pop && !Empty;
  // a pop in the same cycle frees the slot a push into a full FIFO needs
  assign push_ok = Push && (!Full || pop_ok);
  assign RdData  = mem[rd_ptr];
  assign Level   = level;
  always_ff @(posedge Clk) begin
    if (!Rst || Clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      level <= level + (ADDR_W+1)'(push_ok) - (ADDR_W+1)'(pop_ok);
    end
  end
  always_ff @(posedge Clk)
    if (Rst && !Clear && push_ok) mem[wr_ptr] <= WrData;
endmodule

// File: rtl/adc_sample_fifo.sv
// adc_sample_fifo: captures ADC results on RD rising edge into a show-ahead FIFO,
// flagging and counting captures dropped while full
module adc_sample_fifo
  import adc_pkg::*;
#(
  parameter int DATA_W = ADC_DATA_W,
  parameter int DEPTH  = ADC_FIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int DROP_W = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              CS,
  input  logic              RD,
  input  logic [DATA_W-1:0] D,
  input  logic              Clear,
  output logic [DATA_W-1:0] SampleData,
  output logic              SampleValid,
  input  logic              SampleReady,
  output logic [ADDR_W:0]   Level,
  output logic              Full,
  output logic              Overflow,
  output logic [DROP_W-1:0] DropCount
);
  logic [DATA_W-1:0] d_q;
  logic              rd_q, cap, pop, drop, empty;
  // d_q still holds the bus value from the last cycle RD was low
  assign cap         = !rd_q && RD && !CS;
  assign pop         = SampleValid && SampleReady;
  assign drop        = cap && Full && !pop;
  assign SampleValid = !empty;
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      d_q       <= '0;
      rd_q      <= 1'b1;
      Overflow  <= 1'b0;
      DropCount <= '0;
    end else begin
      d_q  <= D;
      rd_q <= RD;
      if (Clear) begin
        Overflow  <= 1'b0;
        DropCount <= '0;
      end else if (drop) begin
        Overflow <= 1'b1;
        if (!(&DropCount)) DropCount <= DropCount + 1'b1;
      end
    end
  end
  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
    .Clk    (Clk),
    .Rst    (Rst),
    .Clear  (Clear),
    .Push   (cap),
    .Pop    (SampleReady),
    .WrData (d_q),
    .RdData (SampleData),
    .Level  (Level),
    .Full   (Full),
    .Empty  (empty)
  );
endmodule

// File: tb/tb_adc_sample_fifo.sv
// tb_adc_sample_fifo: table-driven vectors plus directed multi-cycle sequences
module tb_adc_sample_fifo;
  import adc_pkg::*;
  logic       Clk = 1'b0, Rst = 1'b0, CS = 1'b0, RD = 1'b1, Clear = 1'b0, SampleReady = 1'b0;
  sample_t    D = '0, SampleData;
  logic       SampleValid, Full, Overflow;
  logic [4:0] Level;
  logic [7:0] DropCount;
  int         n_vec = 0, n_err = 0;

  typedef struct {
    logic cs, rd; sample_t d; logic rdy, clr;
    logic v; sample_t q; int lvl; logic ovf;
  } vec_t;
  vec_t tbl [16];

  adc_sample_fifo dut (
    .Clk(Clk), .Rst(Rst), .CS(CS), .RD(RD), .D(D), .Clear(Clear),
    .SampleData(SampleData), .SampleValid(SampleValid), .SampleReady(SampleReady),
    .Level(Level), .Full(Full), .Overflow(Overflow), .DropCount(DropCount)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse(input int v);
    RD = 1'b0; D = sample_t'(v); step();
    RD = 1'b1; step();
  endtask

  task automatic fill(input int first, input int n);
    for (int k = 0; k < n; k++) pulse(first + k);
  endtask

  task automatic drain(input int first, input int n);
    for (int k = 0; k < n; k++) begin
      chk("drain_valid", int'(SampleValid), 1);
      chk("drain_data", int'(SampleData), (first + k) & 8'hFF);
      SampleReady = 1'b1; step(); SampleReady = 1'b0;
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_valid"}, int'(SampleValid), 0);
    chk({name, "_level"}, int'(Level), 0);
    chk({name, "_full"}, int'(Full), 0);
    chk({name, "_ovf"}, int'(Overflow), 0);
    chk({name, "_drop"}, int'(DropCount), 0);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 8'h11, 1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11, 1, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11, 2, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 8'h22, 1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 8'h44, 1'b0, 1'b0, 1'b1, 8'h22, 1, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0};

    step(); step();
    chk_idle("reset");
    Rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      CS = tbl[i].cs; RD = tbl[i].rd; D = tbl[i].d; SampleReady = tbl[i].rdy; Clear = tbl[i].clr;
      step();
      chk($sformatf("vec%0d_valid", i), int'(SampleValid), int'(tbl[i].v));
      chk($sformatf("vec%0d_level", i), int'(Level), tbl[i].lvl);
      chk($sformatf("vec%0d_ovf", i), int'(Overflow), int'(tbl[i].ovf));
      if (tbl[i].v) chk($sformatf("vec%0d_data", i), int'(SampleData), int'(tbl[i].q));
    end
    CS = 1'b0; RD = 1'b1; SampleReady = 1'b0; Clear = 1'b0;

    fill(0, 16);
    chk("fill_full", int'(Full), 1);
    chk("fill_level", int'(Level), 16);
    drain(0, 16);
    chk_idle("drain1");
    fill(16, 16);
    chk("fill2_full", int'(Full), 1);
    drain(16, 16);
    chk_idle("drain2");

    fill(0, 16);
    fill(100, 3);
    chk("drop_ovf", int'(Overflow), 1);
    chk("drop_cnt", int'(DropCount), 3);
    chk("drop_level", int'(Level), 16);
    drain(0, 16);
    chk("ovf_sticky", int'(Overflow), 1);
    fill(50, 2);
    Clear = 1'b1; step(); Clear = 1'b0;
    chk_idle("clear");

    fill(0, 16);
    RD = 1'b0; D = 8'h77; step();
    RD = 1'b1; SampleReady = 1'b1; step(); SampleReady = 1'b0;
    chk("popcap_level", int'(Level), 16);
    chk("popcap_ovf", int'(Overflow), 0);
    drain(1, 15);
    chk("popcap_last", int'(SampleData), 8'h77);
    SampleReady = 1'b1; step(); SampleReady = 1'b0;
    chk_idle("popcap_end");

    RD = 1'b0; D = 8'h5A;
    for (int k = 0; k < 10; k++) step();
    RD = 1'b1; step(); step(); step();
    chk("longrd_level", int'(Level), 1);
    chk("longrd_data", int'(SampleData), 8'h5A);
    SampleReady = 1'b1; step(); SampleReady = 1'b0;
    chk_idle("longrd_end");

    fill(0, 16);
    fill(0, 300);
    chk("sat_cnt", int'(DropCount), 255);
    chk("sat_ovf", int'(Overflow), 1);
    Clear = 1'b1; step(); Clear = 1'b0;
    chk_idle("sat_clear");

    fill(7, 2);
    RD = 1'b0; D = 8'h99; step();
    Rst = 1'b0; step();
    chk_idle("midrst");
    Rst = 1'b1; RD = 1'b1; step(); step();
    chk_idle("midrst_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/adc_sample_fifo.md
Name: adc_sample_fifo

Overview:
- Downstream consumer of the ADC timing manager.
- Captures each 8-bit conversion result from the ADC parallel bus on the timing manager's RD strobe (RD low, then high, while CS low).
- Buffers results in a small show-ahead FIFO and presents them to later stages (display/UART/DSP) over a valid/ready handshake.
- Flags and counts samples dropped when the FIFO is full.

Parameters:
- DATA_W, 8, width of ADC data bus and of stored samples.
- DEPTH, 16, FIFO entries; must be a power of 2, at least 2.
- ADDR_W, 4, log2(DEPTH).
- DROP_W, 8, width of the saturating dropped-sample counter.

Ports:
- Clk  in  1  system clock; all logic on posedge.
- Rst  in  1  reset, synchronous, active-low.
- CS  in  1  ADC chip select from the timing manager (active-low).
- RD  in  1  ADC read strobe from the timing manager (active-low).
- D  in  DATA_W  ADC parallel data bus.
- Clear  in  1  synchronous flush of FIFO, Overflow flag and DropCount.
- SampleData  out  DATA_W  head-of-FIFO sample (show-ahead).
- SampleValid  out  1  FIFO non-empty.
- SampleReady  in  1  consumer accepts SampleData this cycle.
- Level  out  ADDR_W+1  current occupancy, 0..DEPTH.
- Full  out  1  Level == DEPTH.
- Overflow  out  1  sticky; set when a capture is dropped.
- DropCount  out  DROP_W  number of dropped captures, saturating at all-ones.

Behaviour:
- Reset is synchronous: when Rst=0 at a posedge, all of the following take effect at that edge.
  - Read and write pointers go to 0; Level=0; SampleValid=0; Full=0; Overflow=0; DropCount=0.
  - rd_q=1 and d_q=0.
  - Memory contents are don't-care; SampleData is don't-care while SampleValid=0.
- Input registering, every cycle: d_q<=D and rd_q<=RD. No synchronizer is needed because RD/CS share Clk. D is external but stable while RD is low.
- Capture event (cap): rd_q==0 && RD==1 && CS==0. d_q then holds D sampled on the last edge RD was low.
- Push:
  - cap && !Full writes d_q at wr_ptr; wr_ptr increments and wraps modulo DEPTH.
  - cap && Full && pop in the same cycle counts as not full: the push is accepted and Level is unchanged.
- Drop: cap && Full && !pop.
  - Sample is discarded; Overflow<=1; DropCount increments unless it is already all-ones.
- Pop: SampleValid && SampleReady; rd_ptr increments and wraps.
  - SampleReady while empty has no effect.
- Level update: +1 on push-only, -1 on pop-only, unchanged on both or neither.
  - SampleValid = (Level != 0); Full = (Level == DEPTH). Both are registered or derived from the registered Level.
- Latency: a capture at edge E gives SampleValid=1 and the correct SampleData after E, when the FIFO was empty. Capture-to-output is 1 cycle after the RD rising edge is seen.
- SampleData = mem[rd_ptr] (combinational read). It holds stable while SampleValid=1 and SampleReady=0.
- Clear has priority over push and pop in the same cycle.
  - Pointers, Level, Overflow and DropCount go to 0.
  - A capture in that cycle is lost and not counted.
- Ordering: strictly FIFO. No reordering and no duplicate capture per RD pulse, however long RD stays low.
- If CS is high on the RD rising edge, there is no capture.
- Reset asserted mid-RD-pulse: the pulse is not captured, because rd_q reloads 1.

Decomposition:
- Shared package (adc_pkg):
  - ADC_DATA_W=8.
  - The default FIFO depth.
  - A sample typedef (logic [ADC_DATA_W-1:0]).
- One sub-module: sync_fifo. It is a generic show-ahead FIFO with push/pop/clear/level/full/empty.
- adc_sample_fifo contains the strobe capture, drop logic and counter, and instantiates sync_fifo.

Test Plan:
- Reset, then a single RD pulse (RD low 2 cycles, CS=0, D=8'hA5) -> SampleValid=1 one cycle after RD rises; SampleData=8'hA5; Level=1; pop with SampleReady -> Level=0, SampleValid=0.
- 16 RD pulses with D=0..15 and SampleReady=0 -> Full=1, Level=16; then drain -> data 0..15 in order, with pointers wrapping correctly on a second fill of 16..31.
- Fill to 16, then 3 more pulses with SampleReady=0 -> Overflow=1, DropCount=3, stored data still 0..15; Clear -> Overflow=0, DropCount=0, Level=0.
- Full FIFO with SampleReady=1 coinciding with a capture of 8'h77 -> no drop, Level stays 16, 8'h77 read last.
- RD pulse with CS=1 -> no capture; RD held low 10 cycles then high -> exactly one capture; 300 drops -> DropCount saturates at 255.
- Rst=0 during an RD-low interval, then RD rises after reset release -> no capture, all outputs at reset values.
